// File: rtl/sif_address_rx.sv
// Receive end of the SIF addressing link: synchronizes the serial clock/data,
// shifts in a 12-bit {tx_add_1, tx_add_2, rx_add} frame LSB-first, validates
// it and drives registered addresses plus one-hot selects to the switch matrix.
module sif_address_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_clk_i,
  input  logic        spi_data_i,
  input  logic        mode_i,
  output logic [3:0]  tx_add_1_o,
  output logic [3:0]  tx_add_2_o,
  output logic [3:0]  rx_add_o,
  output logic [15:0] tx_sel_o,
  output logic [15:0] rx_sel_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_p0, data_sync_p0;
  logic                   clk_prev_p1;
  logic                   clk_s, data_s, spi_edge;

  logic [11:0]   sreg_q, sreg_d;
  logic [3:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    tx1_q, tx1_d, tx2_q, tx2_d, rx_q, rx_d;
  logic [15:0]   tx_sel_q, tx_sel_d, rx_sel_q, rx_sel_d;
  logic          valid_q, valid_d, err_q, err_d;

  // Address to one-hot switch select.
  function automatic logic [15:0] onehot(input logic [3:0] a);
    onehot = 16'h0001 << a;
  endfunction

  // Matched synchronizer chains for clock and data, plus the edge-detect flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_p0  <= '0;
      data_sync_p0 <= '0;
      clk_prev_p1  <= 1'b0;
    end else begin
      clk_sync_p0[0]  <= spi_clk_i;
      data_sync_p0[0] <= spi_data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync_p0[i]  <= clk_sync_p0[i-1];
        data_sync_p0[i] <= data_sync_p0[i-1];
      end
      clk_prev_p1 <= clk_s;
    end
  end

  assign clk_s    = clk_sync_p0[SYNC_STAGES-1];
  assign data_s   = data_sync_p0[SYNC_STAGES-1];
  assign spi_edge = clk_s & ~clk_prev_p1;

  // --- stage p1: frame state, shift register and registered outputs ---
  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      tx1_q    <= '0;
      tx2_q    <= '0;
      rx_q     <= '0;
      tx_sel_q <= '0;
      rx_sel_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      tx1_q    <= tx1_d;
      tx2_q    <= tx2_d;
      rx_q     <= rx_d;
      tx_sel_q <= tx_sel_d;
      rx_sel_q <= rx_sel_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: receive bits, time out stalled frames, validate in CHECK.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    count_d  = count_q;
    timer_d  = timer_q;
    tx1_d    = tx1_q;
    tx2_d    = tx2_q;
    rx_d     = rx_q;
    tx_sel_d = tx_sel_q;
    rx_sel_d = rx_sel_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        timer_d = '0;
        if (spi_edge) begin
          sreg_d  = {data_s, sreg_q[11:1]};
          count_d = 4'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (spi_edge) begin
          sreg_d  = {data_s, sreg_q[11:1]};
          count_d = count_q + 4'd1;
          timer_d = '0;
          if (count_q == 4'd11) state_d = CHECK;
        end else if (timer_q == TMAX) begin
          // Stalled transmitter: drop the partial frame.
          err_d   = 1'b1;
          sreg_d  = '0;
          count_d = '0;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CHECK: begin
        count_d = '0;
        timer_d = '0;
        state_d = IDLE;
        // Two identical tx addresses are only meaningful for continuity.
        if ((sreg_q[11:8] == sreg_q[7:4]) && !mode_i) begin
          err_d = 1'b1;
        end else begin
          tx1_d    = sreg_q[11:8];
          tx2_d    = sreg_q[7:4];
          rx_d     = sreg_q[3:0];
          tx_sel_d = onehot(sreg_q[11:8]) | onehot(sreg_q[7:4]);
          rx_sel_d = onehot(sreg_q[3:0]);
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_add_1_o = tx1_q;
  assign tx_add_2_o = tx2_q;
  assign rx_add_o   = rx_q;
  assign tx_sel_o   = tx_sel_q;
  assign rx_sel_o   = rx_sel_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);

endmodule
